button_debouncer: RTL
=====================

// Module: button_debouncer
// PURPOSE
//   Input-side companion to the LED outputs on the board.
//   - Samples N raw mechanical push-buttons and synchronizes each one into i_clk.
//   - Debounces each button independently.
//   - Presents a clean level per button, plus one-cycle press and release strobes.
//   - Sits between the board pins and user logic, e.g. to change LED patterns or counter rates.
// PARAMETERS
//   N_BTN            4        number of independent button channels (>=1)
//   DEBOUNCE_CYCLES  250000   consecutive stable cycles needed to accept a new level (>=2)
//   CNT_WIDTH        18       debounce counter width; must satisfy 2**CNT_WIDTH > DEBOUNCE_CYCLES
//   LONG_CYCLES      25000000 held cycles before the long-press strobe fires (macro builds only)
//   LONG_WIDTH       25       long-press counter width; must satisfy 2**LONG_WIDTH > LONG_CYCLES
// PORTS
//   i_clk      in   1      single system clock; all logic on posedge
//   i_rst      in   1      asynchronous, active-high reset
//   i_btn      in   N_BTN  raw button pins, 1 = pressed, asynchronous to i_clk
//   o_state    out  N_BTN  debounced level per button, registered
//   o_press    out  N_BTN  one-cycle strobe on an accepted 0->1 transition
//   o_release  out  N_BTN  one-cycle strobe on an accepted 1->0 transition
//   o_long     out  N_BTN  one-cycle long-press strobe; constant 0 without the macro
// BEHAVIOUR
//   - Reset: i_rst high asynchronously clears all flops.
//     - Synchronizer flops, counters, o_state, o_press, o_release and o_long all go to 0.
//     - Reset mid-debounce discards the partial count; no strobe is emitted.
//   - Synchronizer: 2-flop chain per bit. s = second-stage output. Never use i_btn directly.
//   - Per channel, each posedge:
//     - s == o_state: counter <= 0.
//     - s != o_state and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
//     - s != o_state and counter == DEBOUNCE_CYCLES-1: o_state <= s and counter <= 0.
//       Pulse o_press (s=1) or o_release (s=0) high for exactly this one cycle.
//   - A mismatch must therefore persist DEBOUNCE_CYCLES consecutive cycles to be accepted.
//   - Any glitch shorter than that returns the counter to 0 and produces no output change.
//   - Latency: i_btn edge to o_state/strobe = 2 (sync) + DEBOUNCE_CYCLES cycles.
//     - o_press/o_release assert in the same cycle o_state changes.
//   - Strobes are registered, never combinational, and never both high at once on a channel.
//   - Channels are fully independent; simultaneous events on several channels are all reported.
//   - The counter saturates by construction (it never exceeds DEBOUNCE_CYCLES-1), so no wrap.
//   - Button held through reset release: o_state starts at 0; press reported 2+DEBOUNCE_CYCLES later.
// CONFIGURATION
//   BTN_LONG_PRESS_EN defined:
//     - Per-channel hold counter (LONG_WIDTH bits) clears on o_press and increments while o_state=1.
//     - When it reaches LONG_CYCLES-1, o_long pulses for 1 cycle.
//     - The counter then stops, giving one strobe per hold with no auto-repeat.
//     - o_release clears the counter and re-arms the channel.
//   BTN_LONG_PRESS_EN undefined:
//     - Hold counters and LONG_* logic are not built.
//     - o_long is tied to 0; the port list is unchanged.
// TESTING (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=10, N_BTN=4)
//   1. i_rst pulsed mid-run with i_btn=4'hF -> all outputs 0 immediately, before the next posedge.
//   2. i_btn[0] 0->1 held -> o_state[0]=1 and o_press[0] one-cycle pulse, exactly 6 cycles after edge.
//   3. i_btn[1] high for 3 cycles then low -> o_state[1] stays 0; no strobes on any channel.
//   4. i_btn[2] chatters 1,0,1,0 then holds 1 -> exactly one o_press[2], 6 cycles after the final rising edge.
//   5. i_btn=4'hF simultaneously, later 4'h0 -> o_press=4'hF in one cycle; later o_release=4'hF in one cycle.
//   6. Macro on, i_btn[3] held 30 cycles -> exactly one o_long[3], 10 cycles after o_press[3]; macro off -> o_long stays 0.

Source files
------------

// File: rtl/button_debouncer.sv
// Button debouncer: synchronizes N raw push-buttons into i_clk, debounces each channel
// independently and reports a clean level plus one-cycle press/release strobes.
// Optional feature macro: BTN_LONG_PRESS_EN adds a per-channel long-press strobe on o_long;
// without it o_long is tied low and the hold counters are not built.
module button_debouncer #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_WIDTH       = 18,
  parameter int unsigned LONG_CYCLES     = 25000000,
  parameter int unsigned LONG_WIDTH      = 25
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_state,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long
);

  // Elaboration-time sanity checks on the counter sizing.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if ((CNT_WIDTH < 32) && ((64'd1 << CNT_WIDTH) <= 64'(DEBOUNCE_CYCLES))) begin : g_bad_cnt
    $error("CNT_WIDTH too narrow to hold DEBOUNCE_CYCLES-1");
  end
  if ((LONG_WIDTH < 32) && ((64'd1 << LONG_WIDTH) <= 64'(LONG_CYCLES))) begin : g_bad_long
    $error("LONG_WIDTH too narrow to hold LONG_CYCLES-1");
  end

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]     sync1_q;
  logic [N_BTN-1:0]     sync2_q;
  logic [CNT_WIDTH-1:0] cnt_q [N_BTN];
  logic [CNT_WIDTH-1:0] cnt_d [N_BTN];
  logic [N_BTN-1:0]     state_q, state_d;
  logic [N_BTN-1:0]     press_q, press_d;
  logic [N_BTN-1:0]     release_q, release_d;

  // Two-flop synchronizer; only sync2_q is ever consumed downstream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: count consecutive mismatches, accept on the last one.
  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != state_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          // Counter returns to 0 here, so it can never pass CntMax.
          state_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Debounce state, counters and registered strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_state   = state_q;
  assign o_press   = press_q;
  assign o_release = release_q;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [LONG_WIDTH-1:0] LongMax = LONG_WIDTH'(LONG_CYCLES - 1);

  logic [LONG_WIDTH-1:0] hold_q [N_BTN];
  logic [LONG_WIDTH-1:0] hold_d [N_BTN];
  logic [N_BTN-1:0]      done_q, done_d;
  logic [N_BTN-1:0]      long_q, long_d;

  // Hold counter: restart on press/release, fire once at the limit, then park until re-armed.
  always_comb begin
    done_d = done_q;
    long_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hold_d[i] = hold_q[i];
      if (press_d[i] || release_d[i]) begin
        hold_d[i] = '0;
        done_d[i] = 1'b0;
      end else if (state_q[i] && !done_q[i]) begin
        if (hold_q[i] == LongMax) begin
          long_d[i] = 1'b1;
          done_d[i] = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + LONG_WIDTH'(1);
        end
      end
    end
  end

  // Long-press state and registered strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        hold_q[i] <= '0;
      end
      done_q <= '0;
      long_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        hold_q[i] <= hold_d[i];
      end
      done_q <= done_d;
      long_q <= long_d;
    end
  end

  assign o_long = long_q;
`else
  assign o_long = '0;
`endif

endmodule
